// File: rtl/reorder_buffer.sv
// Circular in-order commit queue: allocates at tail, captures CDB results, retires from head.
// Optional ROB_BYPASS_EN: operand queries also see a same-cycle CDB broadcast.
module reorder_buffer #(
    parameter int ROB_BIT = 3,
    parameter int REG_BIT = 5
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               issue_en,
    input  logic [1:0]         issue_type,
    input  logic [REG_BIT-1:0] issue_rd,
    input  logic               issue_pred,
    input  logic [31:0]        issue_alt_pc,
    output logic [ROB_BIT-1:0] tail_id,
    output logic               full,
    input  logic               cdb_en,
    input  logic [ROB_BIT-1:0] cdb_id,
    input  logic [31:0]        cdb_value,
    input  logic               cdb_taken,
    input  logic [ROB_BIT-1:0] qry1_id,
    input  logic [ROB_BIT-1:0] qry2_id,
    output logic               qry1_ready,
    output logic               qry2_ready,
    output logic [31:0]        qry1_value,
    output logic [31:0]        qry2_value,
    output logic               write_en,
    output logic [REG_BIT-1:0] reg_id,
    output logic [ROB_BIT-1:0] rob_id,
    output logic [31:0]        value,
    output logic               store_commit,
    output logic               clear_all,
    output logic [31:0]        redirect_pc
);

    localparam int SIZE = 1 << ROB_BIT;
    localparam logic [1:0] TYPE_STORE  = 2'd1;
    localparam logic [1:0] TYPE_BRANCH = 2'd2;

    logic [SIZE-1:0]    e_valid;
    logic [SIZE-1:0]    e_ready;
    logic [1:0]         e_type   [SIZE];
    logic [REG_BIT-1:0] e_rd     [SIZE];
    logic               e_pred   [SIZE];
    logic               e_taken  [SIZE];
    logic [31:0]        e_alt_pc [SIZE];
    logic [31:0]        e_value  [SIZE];

    logic [ROB_BIT-1:0] head;
    logic [ROB_BIT-1:0] tail;
    logic [ROB_BIT:0]   count;

    logic head_done;
    logic mispredict;
    logic discard;
    logic do_issue;
    logic do_cdb;
    logic q1_byp;
    logic q2_byp;
    logic q1_hit;
    logic q2_hit;

    // count never exceeds SIZE, so its top bit alone marks the full state
    assign full    = count[ROB_BIT];
    assign tail_id = tail;

    always_comb begin
        head_done  = e_valid[head] & e_ready[head];
        mispredict = head_done && (e_type[head] == TYPE_BRANCH) && (e_taken[head] != e_pred[head]);
        // younger work arriving in the flush cycle or the cycle after is wrong-path
        discard    = mispredict | clear_all;
        do_issue   = issue_en & ~full & ~discard;
        do_cdb     = cdb_en & e_valid[cdb_id] & ~discard;
    end

`ifdef ROB_BYPASS_EN
    assign q1_byp = cdb_en & (cdb_id == qry1_id) & e_valid[qry1_id];
    assign q2_byp = cdb_en & (cdb_id == qry2_id) & e_valid[qry2_id];
`else
    assign q1_byp = 1'b0;
    assign q2_byp = 1'b0;
`endif

    assign q1_hit     = e_valid[qry1_id] & e_ready[qry1_id];
    assign q2_hit     = e_valid[qry2_id] & e_ready[qry2_id];
    assign qry1_ready = q1_hit | q1_byp;
    assign qry2_ready = q2_hit | q2_byp;
    assign qry1_value = q1_byp ? cdb_value : (q1_hit ? e_value[qry1_id] : 32'd0);
    assign qry2_value = q2_byp ? cdb_value : (q2_hit ? e_value[qry2_id] : 32'd0);

    // Entry payload: no reset needed, every read is qualified by the valid/ready bits
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (do_issue) begin
                e_type[tail]   <= issue_type;
                e_rd[tail]     <= issue_rd;
                e_pred[tail]   <= issue_pred;
                e_alt_pc[tail] <= issue_alt_pc;
            end
            if (do_cdb) begin
                e_value[cdb_id] <= cdb_value;
                e_taken[cdb_id] <= cdb_taken;
            end
        end
    end

    // Queue pointers, entry status and registered commit outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            e_valid      <= '0;
            e_ready      <= '0;
            write_en     <= 1'b0;
            store_commit <= 1'b0;
            clear_all    <= 1'b0;
            reg_id       <= '0;
            rob_id       <= '0;
            value        <= '0;
            redirect_pc  <= '0;
        end else if (!rdy_in) begin
            write_en     <= 1'b0;
            store_commit <= 1'b0;
            clear_all    <= 1'b0;
        end else begin
            write_en     <= 1'b0;
            store_commit <= 1'b0;
            clear_all    <= 1'b0;

            if (head_done) begin
                rob_id <= head;
                reg_id <= e_rd[head];
                value  <= e_value[head];
                case (e_type[head])
                    TYPE_STORE:  store_commit <= 1'b1;
                    TYPE_BRANCH: begin
                        write_en <= (e_rd[head] != '0);
                        if (mispredict) begin
                            clear_all   <= 1'b1;
                            redirect_pc <= e_alt_pc[head];
                        end
                    end
                    default:     write_en <= 1'b1;
                endcase
            end

            if (mispredict) begin
                e_valid <= '0;
                e_ready <= '0;
                head    <= '0;
                tail    <= '0;
                count   <= '0;
            end else begin
                if (do_cdb) begin
                    e_ready[cdb_id] <= 1'b1;
                end
                if (do_issue) begin
                    e_valid[tail] <= 1'b1;
                    e_ready[tail] <= 1'b0;
                    tail          <= tail + 1'b1;
                end
                // retirement clears last so it wins over a CDB hitting the head entry
                if (head_done) begin
                    e_valid[head] <= 1'b0;
                    e_ready[head] <= 1'b0;
                    head          <= head + 1'b1;
                end
                case ({do_issue, head_done})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized traffic
// compared against a queue-based program-order model.
module tb_reorder_buffer;
    localparam int SIZE = 8;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, issue_en, issue_pred, cdb_en, cdb_taken;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_alt_pc, cdb_value;
    logic [2:0]  cdb_id, qry1_id, qry2_id;
    logic [2:0]  tail_id, rob_id;
    logic        full, qry1_ready, qry2_ready, write_en, store_commit, clear_all;
    logic [31:0] qry1_value, qry2_value, value, redirect_pc;
    logic [4:0]  reg_id;

    reorder_buffer #(.ROB_BIT(3), .REG_BIT(5)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_en(issue_en), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pred(issue_pred), .issue_alt_pc(issue_alt_pc),
        .tail_id(tail_id), .full(full),
        .cdb_en(cdb_en), .cdb_id(cdb_id), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
        .qry1_id(qry1_id), .qry2_id(qry2_id), .qry1_ready(qry1_ready), .qry2_ready(qry2_ready),
        .qry1_value(qry1_value), .qry2_value(qry2_value),
        .write_en(write_en), .reg_id(reg_id), .rob_id(rob_id), .value(value),
        .store_commit(store_commit), .clear_all(clear_all), .redirect_pc(redirect_pc)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [2:0]  id;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic        pred;
        logic [31:0] alt;
        logic        ready;
        logic [31:0] val;
        logic        taken;
    } ent_t;

    ent_t        q[$];
    logic [2:0]  m_tail;
    logic        exp_we, exp_sc, exp_clr;
    logic [4:0]  exp_reg;
    logic [2:0]  exp_rob;
    logic [31:0] exp_val, exp_pc;
    int          checks, errors;

    function automatic int find(input logic [2:0] id);
        for (int i = 0; i < q.size(); i++)
            if (q[i].id == id) return i;
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_tail = 3'd0;
        exp_we = 1'b0; exp_sc = 1'b0; exp_clr = 1'b0;
        exp_reg = '0; exp_rob = '0; exp_val = '0; exp_pc = '0;
    endtask

    // One clock edge of the program-order model, using the inputs present at the edge
    task automatic model_step();
        logic  commit, mis, prev_clr, was_full;
        ent_t  h, n;
        int    k;
        if (!rdy_in) begin
            exp_we = 1'b0; exp_sc = 1'b0; exp_clr = 1'b0;
            return;
        end
        prev_clr = exp_clr;
        was_full = (q.size() == SIZE);
        commit   = (q.size() > 0) && q[0].ready;
        mis      = 1'b0;
        exp_we = 1'b0; exp_sc = 1'b0; exp_clr = 1'b0;
        if (commit) begin
            h = q[0];
            exp_rob = h.id;
            if (h.typ == 2'd1) exp_sc = 1'b1;
            else if (h.typ == 2'd2) begin
                if (h.rd != 5'd0) begin exp_we = 1'b1; exp_reg = h.rd; exp_val = h.val; end
                if (h.taken != h.pred) begin mis = 1'b1; exp_clr = 1'b1; exp_pc = h.alt; end
            end else begin
                exp_we = 1'b1; exp_reg = h.rd; exp_val = h.val;
            end
        end
        if (mis) begin
            q.delete();
            m_tail = 3'd0;
            return;
        end
        if (cdb_en && !prev_clr) begin
            k = find(cdb_id);
            if (k >= 0) begin q[k].ready = 1'b1; q[k].val = cdb_value; q[k].taken = cdb_taken; end
        end
        if (commit) void'(q.pop_front());
        if (issue_en && !was_full && !prev_clr) begin
            n.id = m_tail; n.typ = issue_type; n.rd = issue_rd; n.pred = issue_pred;
            n.alt = issue_alt_pc; n.ready = 1'b0; n.val = '0; n.taken = 1'b0;
            q.push_back(n);
            m_tail = m_tail + 3'd1;
        end
    endtask

    task automatic exp_qry(input logic [2:0] id, output logic rdy, output logic [31:0] v);
        int k;
        k = find(id);
        rdy = 1'b0; v = '0;
        if (k >= 0 && q[k].ready) begin rdy = 1'b1; v = q[k].val; end
`ifdef ROB_BYPASS_EN
        if (cdb_en && cdb_id == id && k >= 0) begin rdy = 1'b1; v = cdb_value; end
`endif
    endtask

    task automatic idle();
        issue_en = 1'b0; issue_type = 2'd0; issue_rd = '0; issue_pred = 1'b0; issue_alt_pc = '0;
        cdb_en = 1'b0; cdb_id = '0; cdb_value = '0; cdb_taken = 1'b0;
        qry1_id = '0; qry2_id = '0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        idle();
        rdy_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b1;
        #2;
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic set_issue(input logic [1:0] t, input logic [4:0] rd, input logic p, input logic [31:0] alt);
        issue_en = 1'b1; issue_type = t; issue_rd = rd; issue_pred = p; issue_alt_pc = alt;
    endtask

    task automatic set_cdb(input logic [2:0] id, input logic [31:0] v, input logic tk);
        cdb_en = 1'b1; cdb_id = id; cdb_value = v; cdb_taken = tk;
    endtask

    task automatic test_reset();
        checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL reset_we: got %0h want 0", write_en); end
        checks++; if (store_commit !== 1'b0) begin errors++; $display("FAIL reset_sc: got %0h want 0", store_commit); end
        checks++; if (clear_all !== 1'b0) begin errors++; $display("FAIL reset_clr: got %0h want 0", clear_all); end
        checks++; if (tail_id !== 3'd0) begin errors++; $display("FAIL reset_tail: got %0h want 0", tail_id); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0h want 0", full); end
        checks++; if ({reg_id, rob_id, value, redirect_pc} !== '0) begin errors++; $display("FAIL reset_data: got %0h/%0h/%0h/%0h want 0", reg_id, rob_id, value, redirect_pc); end
        checks++; if (qry1_ready !== 1'b0) begin errors++; $display("FAIL reset_qry: got %0h want 0", qry1_ready); end
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic test_basic_commit();
        apply_reset();
        set_issue(2'd0, 5'd5, 1'b0, 32'h0);
        tick();
        idle();
        checks++; if (tail_id !== 3'd1) begin errors++; $display("FAIL basic_tail: got %0h want 1", tail_id); end
        set_cdb(3'd0, 32'h1234, 1'b0);
        tick();
        idle();
        checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL basic_early: got %0h want 0", write_en); end
        tick();
        checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL basic_we: got %0h want 1", write_en); end
        checks++; if (reg_id !== 5'd5) begin errors++; $display("FAIL basic_reg: got %0h want 5", reg_id); end
        checks++; if (rob_id !== 3'd0) begin errors++; $display("FAIL basic_rob: got %0h want 0", rob_id); end
        checks++; if (value !== 32'h1234) begin errors++; $display("FAIL basic_val: got %0h want 1234", value); end
        tick();
        checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %0h want 0", write_en); end
    endtask

    task automatic test_full_wrap();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            set_issue(2'd0, 5'(i + 1), 1'b0, 32'h0);
            tick();
            if (i == 6) begin
                checks++; if (tail_id !== 3'd7) begin errors++; $display("FAIL full_tail7: got %0h want 7", tail_id); end
            end
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_set: got %0h want 1", full); end
        checks++; if (tail_id !== 3'd0) begin errors++; $display("FAIL full_wrap: got %0h want 0", tail_id); end
        tick();
        idle();
        checks++; if (tail_id !== 3'd0 || full !== 1'b1) begin errors++; $display("FAIL full_ignore: got tail %0h full %0h want 0/1", tail_id, full); end
        set_cdb(3'd0, 32'hAA, 1'b0);
        tick();
        idle();
        tick();
        checks++; if (write_en !== 1'b1 || rob_id !== 3'd0 || reg_id !== 5'd1) begin errors++; $display("FAIL full_commit: got we %0h rob %0h reg %0h want 1/0/1", write_en, rob_id, reg_id); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_clear: got %0h want 0", full); end
        set_issue(2'd0, 5'd9, 1'b0, 32'h0);
        tick();
        idle();
        checks++; if (full !== 1'b1 || tail_id !== 3'd1) begin errors++; $display("FAIL full_refill: got full %0h tail %0h want 1/1", full, tail_id); end
    endtask

    task automatic test_out_of_order();
        apply_reset();
        set_issue(2'd0, 5'd1, 1'b0, 32'h0); tick();
        set_issue(2'd0, 5'd2, 1'b0, 32'h0); tick();
        idle();
        set_cdb(3'd1, 32'h11, 1'b0); tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL ooo_wait: got %0h want 0", write_en); end
        end
        set_cdb(3'd0, 32'h10, 1'b0); tick();
        idle();
        tick();
        checks++; if (write_en !== 1'b1 || rob_id !== 3'd0 || value !== 32'h10) begin errors++; $display("FAIL ooo_first: got we %0h rob %0h val %0h want 1/0/10", write_en, rob_id, value); end
        tick();
        checks++; if (write_en !== 1'b1 || rob_id !== 3'd1 || value !== 32'h11) begin errors++; $display("FAIL ooo_second: got we %0h rob %0h val %0h want 1/1/11", write_en, rob_id, value); end
    endtask

    task automatic test_mispredict();
        apply_reset();
        set_issue(2'd2, 5'd0, 1'b1, 32'h100); tick();
        set_issue(2'd0, 5'd3, 1'b0, 32'h0); tick();
        set_issue(2'd0, 5'd4, 1'b0, 32'h0); tick();
        idle();
        set_cdb(3'd1, 32'h5, 1'b0); tick();
        set_cdb(3'd0, 32'h0, 1'b0); tick();
        idle();
        tick();
        checks++; if (clear_all !== 1'b1) begin errors++; $display("FAIL mis_clear: got %0h want 1", clear_all); end
        checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL mis_pc: got %0h want 100", redirect_pc); end
        checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL mis_r0: got %0h want 0", write_en); end
        qry1_id = 3'd1;
        #1;
        checks++; if (tail_id !== 3'd0 || full !== 1'b0 || qry1_ready !== 1'b0) begin errors++; $display("FAIL mis_flush: got tail %0h full %0h rdy %0h want 0/0/0", tail_id, full, qry1_ready); end
        tick();
        checks++; if (clear_all !== 1'b0 || write_en !== 1'b0) begin errors++; $display("FAIL mis_after: got clr %0h we %0h want 0/0", clear_all, write_en); end
        idle();
        set_issue(2'd2, 5'd7, 1'b0, 32'h200); tick();
        idle();
        set_cdb(3'd0, 32'h44, 1'b1); tick();
        idle();
        tick();
        checks++; if (clear_all !== 1'b1 || write_en !== 1'b1 || reg_id !== 5'd7 || value !== 32'h44 || redirect_pc !== 32'h200) begin
            errors++; $display("FAIL mis_link: got clr %0h we %0h reg %0h val %0h pc %0h want 1/1/7/44/200", clear_all, write_en, reg_id, value, redirect_pc);
        end
        tick();
    endtask

    task automatic test_bypass();
        logic        want_rdy;
        logic [31:0] want_val;
        apply_reset();
        for (int i = 0; i < 3; i++) begin set_issue(2'd0, 5'(i + 1), 1'b0, 32'h0); tick(); end
        idle();
        set_cdb(3'd2, 32'h7, 1'b0);
        qry1_id = 3'd2;
        #1;
`ifdef ROB_BYPASS_EN
        want_rdy = 1'b1; want_val = 32'h7;
`else
        want_rdy = 1'b0; want_val = 32'h0;
`endif
        checks++; if (qry1_ready !== want_rdy || qry1_value !== want_val) begin errors++; $display("FAIL byp_same: got %0h/%0h want %0h/%0h", qry1_ready, qry1_value, want_rdy, want_val); end
        tick();
        cdb_en = 1'b0;
        #1;
        checks++; if (qry1_ready !== 1'b1 || qry1_value !== 32'h7) begin errors++; $display("FAIL byp_next: got %0h/%0h want 1/7", qry1_ready, qry1_value); end
    endtask

    task automatic test_rdy_pause();
        apply_reset();
        set_issue(2'd1, 5'd0, 1'b0, 32'h0); tick();
        idle();
        set_cdb(3'd0, 32'h9, 1'b0); tick();
        idle();
        rdy_in = 1'b0;
        set_issue(2'd0, 5'd2, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (store_commit !== 1'b0) begin errors++; $display("FAIL pause_sc: got %0h want 0", store_commit); end
        end
        checks++; if (tail_id !== 3'd1) begin errors++; $display("FAIL pause_tail: got %0h want 1", tail_id); end
        idle();
        rdy_in = 1'b1;
        tick();
        checks++; if (store_commit !== 1'b1 || rob_id !== 3'd0 || write_en !== 1'b0) begin errors++; $display("FAIL pause_commit: got sc %0h rob %0h we %0h want 1/0/0", store_commit, rob_id, write_en); end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        for (int i = 0; i < 8; i++) begin set_issue(2'd0, 5'(i + 3), 1'b0, 32'h0); tick(); end
        idle();
        set_cdb(3'd0, 32'h55, 1'b0); tick();
        idle();
        tick();
        checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL mid_pre: got %0h want 1", write_en); end
        #2;
        rst_in = 1'b1;
        #1;
        checks++; if (write_en !== 1'b0 || full !== 1'b0 || tail_id !== 3'd0) begin errors++; $display("FAIL mid_async: got we %0h full %0h tail %0h want 0/0/0", write_en, full, tail_id); end
        checks++; if ({reg_id, rob_id, value} !== '0) begin errors++; $display("FAIL mid_data: got %0h/%0h/%0h want 0", reg_id, rob_id, value); end
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic test_random();
        logic        r1, r2;
        logic [31:0] v1, v2;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            rdy_in       = ($urandom_range(0, 9) != 0);
            issue_en     = $urandom_range(0, 1) == 1;
            issue_type   = 2'($urandom_range(0, 2));
            issue_rd     = 5'($urandom);
            issue_pred   = 1'($urandom);
            issue_alt_pc = $urandom;
            cdb_en       = $urandom_range(0, 1) == 1;
            cdb_id       = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[$urandom_range(0, q.size() - 1)].id : 3'($urandom);
            cdb_value    = $urandom;
            cdb_taken    = 1'($urandom);
            qry1_id      = (q.size() > 0) ? q[$urandom_range(0, q.size() - 1)].id : 3'($urandom);
            qry2_id      = 3'($urandom);
            #1;
            exp_qry(qry1_id, r1, v1);
            exp_qry(qry2_id, r2, v2);
            checks++; if (full !== (q.size() == SIZE)) begin errors++; $display("FAIL rnd_full: cyc %0d got %0h want %0h", c, full, q.size() == SIZE); end
            checks++; if (tail_id !== m_tail) begin errors++; $display("FAIL rnd_tail: cyc %0d got %0h want %0h", c, tail_id, m_tail); end
            checks++; if (qry1_ready !== r1 || qry1_value !== v1) begin errors++; $display("FAIL rnd_qry1: cyc %0d got %0h/%0h want %0h/%0h", c, qry1_ready, qry1_value, r1, v1); end
            checks++; if (qry2_ready !== r2 || qry2_value !== v2) begin errors++; $display("FAIL rnd_qry2: cyc %0d got %0h/%0h want %0h/%0h", c, qry2_ready, qry2_value, r2, v2); end
            tick();
            checks++; if (write_en !== exp_we || store_commit !== exp_sc || clear_all !== exp_clr) begin
                errors++; $display("FAIL rnd_pulse: cyc %0d got we %0h sc %0h clr %0h want %0h/%0h/%0h", c, write_en, store_commit, clear_all, exp_we, exp_sc, exp_clr);
            end
            if (exp_we) begin
                checks++; if (reg_id !== exp_reg || value !== exp_val || rob_id !== exp_rob) begin errors++; $display("FAIL rnd_write: cyc %0d got %0h/%0h/%0h want %0h/%0h/%0h", c, reg_id, value, rob_id, exp_reg, exp_val, exp_rob); end
            end
            if (exp_sc) begin
                checks++; if (rob_id !== exp_rob) begin errors++; $display("FAIL rnd_store: cyc %0d got %0h want %0h", c, rob_id, exp_rob); end
            end
            if (exp_clr) begin
                checks++; if (redirect_pc !== exp_pc) begin errors++; $display("FAIL rnd_redirect: cyc %0d got %0h want %0h", c, redirect_pc, exp_pc); end
            end
        end
        idle();
        rdy_in = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        rdy_in = 1'b1;
        rst_in = 1'b1;
        model_reset();
        #12;
        test_reset();
        test_basic_commit();
        test_full_wrap();
        test_out_of_order();
        test_mispredict();
        test_bypass();
        test_rdy_pause();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
